// File: rtl/uart_tx_scheduler_if.sv
// Bundle for the shared UART transmitter: producer handshake plus the line
// and status outputs. Producers use the master side, the scheduler the slave.
interface uart_tx_scheduler_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]         req_valid;
    logic [8*NUM_REQ-1:0]       req_data;
    logic [NUM_REQ-1:0]         req_ready;
    logic                       tx;
    logic                       busy;
    logic [$clog2(NUM_REQ)-1:0] grant_id;
    logic                       tx_done;

    modport master (
        output req_valid, req_data,
        input  req_ready, tx, busy, grant_id, tx_done
    );

    modport slave (
        input  req_valid, req_data,
        output req_ready, tx, busy, grant_id, tx_done
    );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter in front of a single 8N1 UART serializer.
// One byte is accepted per frame, only while the line is idle; the outputs
// tx, busy, tx_done and grant_id are registered.
module uart_tx_scheduler #(
    parameter int NUM_REQ      = 4,
    parameter int CLKS_PER_BIT = 4
) (
    input  logic               clk,
    input  logic               reset,
    uart_tx_scheduler_if.slave bus
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int BW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [GW-1:0] GRANT_RST = GW'(NUM_REQ - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [GW-1:0] last_grant_q, last_grant_d;
    logic [GW-1:0] grant_id_q, grant_id_d;
    logic          tx_q, tx_d;
    logic          busy_q, busy_d;
    logic          tx_done_q, tx_done_d;

    logic [GW:0]   pick;
    logic [GW-1:0] win_idx;
    logic          accept;

    // First valid requester strictly after 'last', wrapping; MSB flags a hit.
    function automatic logic [GW:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                            input logic [GW-1:0]      last);
        logic [GW:0]   res;
        logic [GW-1:0] cand;
        res = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = GW'((int'(last) + i) % NUM_REQ);
            if (!res[GW] && valid[cand]) begin
                res = {1'b1, cand};
            end
        end
        return res;
    endfunction

    assign pick    = rr_pick(bus.req_valid, last_grant_q);
    assign win_idx = pick[GW-1:0];
    // Reset masks ready so nothing is handed over in a cycle that gets discarded.
    assign accept  = (state_q == IDLE) && !reset && pick[GW];

    // Zero-latency ready, one-hot to the winner, only while idle.
    always_comb begin
        bus.req_ready = '0;
        if (accept) begin
            bus.req_ready[win_idx] = 1'b1;
        end
    end

    // Frame sequencing: next state, counters, shift register and next outputs.
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        baud_d       = baud_q;
        last_grant_d = last_grant_q;
        grant_id_d   = grant_id_q;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shift_d      = bus.req_data[{win_idx, 3'b000} +: 8];
                    last_grant_d = win_idx;
                    grant_id_d   = win_idx;
                    bit_cnt_d    = '0;
                    baud_d       = '0;
                    state_d      = START;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        bit_cnt_d = '0;
                        state_d   = STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are precomputed from the next state so the flops present
        // them in the same cycle the state takes effect.
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
        busy_d    = (state_d != IDLE);
        tx_done_d = (state_d == STOP) && (baud_d == BAUD_LAST);
    end

    // Control and output registers; reset aborts any frame in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            baud_q       <= '0;
            last_grant_q <= GRANT_RST;
            grant_id_q   <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            tx_done_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            baud_q       <= baud_d;
            last_grant_q <= last_grant_d;
            grant_id_q   <= grant_id_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            tx_done_q    <= tx_done_d;
        end
    end

    // Data shift register; only read while a frame is active, so no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

    assign bus.tx       = tx_q;
    assign bus.busy     = busy_q;
    assign bus.tx_done  = tx_done_q;
    assign bus.grant_id = grant_id_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: directed scenarios plus randomized traffic,
// with a cycle-level reference model of the line built from frame timing.
module tb_uart_tx_scheduler;
    localparam int NR = 4;
    localparam int C  = 4;
    localparam int GW = $clog2(NR);

    logic clk = 1'b0;
    logic reset;
    int   cyc = 0;
    int   n_total = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_scheduler_if #(.NUM_REQ(NR)) bus ();

    uart_tx_scheduler #(.NUM_REQ(NR), .CLKS_PER_BIT(C)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // observed DUT events
    int          acc_cyc[$];
    int          acc_id[$];
    int          done_cyc[$];
    logic [NR-1:0] rdy_seen = '0;

    // reference model state
    bit          rst_prev = 1'b1;
    bit          m_active = 1'b0;
    int          m_k = 0;
    int          m_last = NR - 1;
    int          m_gid = 0;
    logic [9:0]  m_bits = '1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic bit_of(input logic [31:0] v, input int i);
        logic [31:0] t;
        t = v >> i;
        return t[0];
    endfunction

    // Model: a frame accepted in cycle k occupies cycles k+1..k+10C,
    // bit b of {stop,data,start} lasting C cycles; arbitration is plain
    // round-robin over the current valid vector when the line is free.
    initial begin
        int         e_win;
        int         c;
        int         pos;
        logic       e_tx, e_busy, e_done;
        logic [NR-1:0] e_rdy;
        logic [7:0] byte_v;
        logic [9:0] sh;
        forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                if (rst_prev) begin
                    m_active = 1'b0;
                    m_last   = NR - 1;
                    m_gid    = 0;
                end
                e_tx = 1'b1; e_busy = 1'b0; e_done = 1'b0;
                if (m_active && cyc > m_k && cyc <= m_k + 10*C) begin
                    pos    = (cyc - m_k - 1) / C;
                    sh     = m_bits >> pos;
                    e_tx   = sh[0];
                    e_busy = 1'b1;
                    e_done = (cyc == m_k + 10*C);
                end
                e_rdy = '0;
                e_win = 0;
                if (!reset && !(m_active && cyc <= m_k + 10*C)) begin
                    for (int i = 1; i <= NR; i++) begin
                        c = (m_last + i) % NR;
                        if (e_rdy == '0 && bit_of(32'(bus.req_valid), c)) begin
                            e_rdy = NR'(1) << c;
                            e_win = c;
                        end
                    end
                end
                check("tx",       32'(bus.tx),        32'(e_tx));
                check("busy",     32'(bus.busy),      32'(e_busy));
                check("tx_done",  32'(bus.tx_done),   32'(e_done));
                check("req_ready",32'(bus.req_ready), 32'(e_rdy));
                check("grant_id", 32'(bus.grant_id),  32'(m_gid));

                rdy_seen = bus.req_ready & bus.req_valid;
                if (rdy_seen != '0) begin
                    acc_cyc.push_back(cyc);
                    for (int i = 0; i < NR; i++)
                        if (bit_of(32'(rdy_seen), i)) acc_id.push_back(i);
                end
                if (bus.tx_done) done_cyc.push_back(cyc);

                if (e_rdy != '0) begin
                    byte_v   = 8'(bus.req_data >> (8*e_win));
                    m_active = 1'b1;
                    m_k      = cyc;
                    m_last   = e_win;
                    m_gid    = e_win;
                    m_bits   = {1'b1, byte_v, 1'b0};
                end
            end
            rst_prev = reset;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int t);
        int g;
        g = 0;
        while (cyc < t && g < 5000) begin
            tick();
            g++;
        end
    endtask

    task automatic wait_acc(input int want);
        int g;
        g = 0;
        while (acc_cyc.size() < want && g < 400) begin
            tick();
            g++;
        end
        check("accept_wait", 32'(acc_cyc.size() >= want), 32'd1);
    endtask

    task automatic wait_done(input int want);
        int g;
        g = 0;
        while (done_cyc.size() < want && g < 400) begin
            tick();
            g++;
        end
        check("done_wait", 32'(done_cyc.size() >= want), 32'd1);
    endtask

    task automatic wait_idle();
        if (acc_cyc.size() > 0) wait_cyc(acc_cyc[acc_cyc.size()-1] + 10*C + 2);
        else tick();
    endtask

    initial begin
        int         n0, k, k0, nd;
        logic [9:0] a5_seq;
        logic [7:0] nb;
        logic [NR-1:0]   vld;
        logic [8*NR-1:0] dat;
        logic [8*NR-1:0] mask;

        a5_seq        = 10'b1101001010;
        reset         = 1'b1;
        bus.req_valid = '1;
        bus.req_data  = {8'h44, 8'h33, 8'h22, 8'hA5};

        // reset held with all requesters valid, then single frame 0xA5
        repeat (3) tick();
        reset = 1'b0;
        wait_acc(1);
        bus.req_valid = '0;
        if (acc_id.size() >= 1) begin
            check("first_grant", 32'(acc_id[0]), 32'd0);
            k = acc_cyc[0];
            for (int b = 0; b < 10; b++) begin
                wait_cyc(k + 1 + C*b + C/2);
                check("a5_bit", 32'(bus.tx), 32'(bit_of(32'(a5_seq), b)));
            end
            wait_done(1);
            if (done_cyc.size() >= 1) check("a5_done_lat", 32'(done_cyc[0] - k), 32'(10*C));
            check("a5_gid", 32'(bus.grant_id), 32'd0);
        end
        wait_idle();

        // all four requesters held valid after a fresh reset
        bus.req_data  = {8'h44, 8'h33, 8'h22, 8'h11};
        bus.req_valid = '1;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n0 = acc_cyc.size();
        wait_acc(n0 + 5);
        bus.req_valid = '0;
        if (acc_cyc.size() >= n0 + 5) begin
            check("rr_order0", 32'(acc_id[n0+0]), 32'd0);
            check("rr_order1", 32'(acc_id[n0+1]), 32'd1);
            check("rr_order2", 32'(acc_id[n0+2]), 32'd2);
            check("rr_order3", 32'(acc_id[n0+3]), 32'd3);
            check("rr_order4", 32'(acc_id[n0+4]), 32'd0);
            for (int i = 1; i < 5; i++)
                check("rr_spacing", 32'(acc_cyc[n0+i] - acc_cyc[n0+i-1]), 32'(10*C + 1));
        end
        wait_idle();

        // round-robin skip: grant 1, then only 0 and 2 valid
        n0 = acc_cyc.size();
        bus.req_valid = 4'b0010;
        wait_acc(n0 + 1);
        bus.req_valid = 4'b0101;
        wait_acc(n0 + 3);
        bus.req_valid = '0;
        if (acc_id.size() >= n0 + 3) begin
            check("skip_g1", 32'(acc_id[n0+0]), 32'd1);
            check("skip_g2", 32'(acc_id[n0+1]), 32'd2);
            check("skip_g0", 32'(acc_id[n0+2]), 32'd0);
        end
        wait_idle();

        // reset during data bit 3, then a clean frame from requester 3
        n0 = acc_cyc.size();
        bus.req_data[31:24] = 8'($urandom);
        bus.req_valid = 4'b1000;
        wait_acc(n0 + 1);
        bus.req_valid = '0;
        if (acc_cyc.size() >= n0 + 1) begin
            k = acc_cyc[n0];
            wait_cyc(k + 1 + C*4 + 1);
            nd = done_cyc.size();
            reset = 1'b1;
            tick();
            check("abort_tx",   32'(bus.tx),   32'd1);
            check("abort_busy", 32'(bus.busy), 32'd0);
            reset = 1'b0;
            wait_cyc(k + 10*C + 3);
            check("abort_no_done", 32'(done_cyc.size()), 32'(nd));
        end
        n0 = acc_cyc.size();
        nd = done_cyc.size();
        bus.req_data[31:24] = 8'($urandom);
        bus.req_valid = 4'b1000;
        wait_acc(n0 + 1);
        bus.req_valid = '0;
        wait_done(nd + 1);
        if (acc_cyc.size() >= n0 + 1 && done_cyc.size() >= nd + 1) begin
            check("post_abort_id",  32'(acc_id[n0]), 32'd3);
            check("post_abort_lat", 32'(done_cyc[nd] - acc_cyc[n0]), 32'(10*C));
        end
        wait_idle();

        // late valid from requester 1 while requester 0's frame runs
        n0 = acc_cyc.size();
        bus.req_valid = 4'b0001;
        wait_acc(n0 + 1);
        bus.req_valid = '0;
        repeat (15) tick();
        bus.req_valid = 4'b0010;
        wait_acc(n0 + 2);
        bus.req_valid = '0;
        if (acc_cyc.size() >= n0 + 2) begin
            check("late_id",  32'(acc_id[n0+1]), 32'd1);
            check("late_gap", 32'(acc_cyc[n0+1] - acc_cyc[n0]), 32'(10*C + 1));
        end
        wait_idle();

        // randomized traffic: hold data until accepted, occasional withdraw/reset
        for (int n = 0; n < 1500; n++) begin
            tick();
            vld = bus.req_valid;
            dat = bus.req_data;
            for (int i = 0; i < NR; i++) begin
                nb   = 8'($urandom);
                mask = {{(8*NR-8){1'b0}}, 8'hFF} << (8*i);
                if (bit_of(32'(rdy_seen), i) || !bit_of(32'(vld), i)) begin
                    if ($urandom_range(0, 3) == 0) begin
                        vld = vld | (NR'(1) << i);
                        dat = (dat & ~mask) | ({{(8*NR-8){1'b0}}, nb} << (8*i));
                    end else begin
                        vld = vld & ~(NR'(1) << i);
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    vld = vld & ~(NR'(1) << i);
                end
            end
            bus.req_valid = vld;
            bus.req_data  = dat;
            reset = ($urandom_range(0, 199) == 0);
        end
        reset = 1'b0;
        bus.req_valid = '0;
        repeat (10*C + 4) tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares one UART transmit line between `NUM_REQ` byte producers. The block arbitrates round-robin among requesters and accepts one byte per frame through a valid/ready handshake. It serializes each byte as a standard 8N1 frame (start, 8 data LSB-first, stop), timed by an internal bit-period counter. It sits between the on-chip byte sources and the `Tx` pad, replacing per-source direct drive of the line.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `CLKS_PER_BIT`, 4: clock cycles per UART bit, ≥1.
- `clk`  in  1: clock; all logic on rising edge.
- `reset`  in  1: synchronous, active-high.
- `req_valid`  in  NUM_REQ: bit i high = requester i offers a byte.
- `req_data`  in  8*NUM_REQ: byte of requester i on bits [8i+7:8i].
- `req_ready`  out  NUM_REQ: one-hot or zero; bit i high = byte i accepted this cycle.
- `tx`  out  1: serial line, idle high.
- `busy`  out  1: high while a frame is on the line (START..STOP).
- `grant_id`  out  $clog2(NUM_REQ): index of the requester last accepted.
- `tx_done`  out  1: one-cycle pulse in the final cycle of the stop bit.

## Operation
- States: IDLE, START, DATA, STOP.
- IDLE:
  - `tx`=1, `busy`=0.
  - If any `req_valid` is high, select the winner: the first requester with valid high, searching upward from `last_grant+1` modulo NUM_REQ.
  - `req_ready` is driven combinationally for the winner only, and only in IDLE.
  - On the accepting edge: latch that byte into the shift register; `last_grant`←winner, `grant_id`←winner; bit counter←0; baud counter←0; state→START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then →DATA.
- DATA:
  - `tx`=shift[0], held CLKS_PER_BIT cycles per bit, then shift right.
  - After 8 bits →STOP.
- STOP:
  - `tx`=1 for CLKS_PER_BIT cycles.
  - `tx_done`=1 in the last of those cycles.
  - Then →IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and wraps to 0 on each bit boundary. Width is $clog2(CLKS_PER_BIT)+1.
- Requesters hold `req_data` stable while `req_valid` is high until accepted.
  - Dropping valid before acceptance withdraws the request; nothing is transmitted for it.
  - Valid raised during a frame waits; `req_ready` stays 0 outside IDLE.
- Reset values: `tx`=1, `busy`=0, `req_ready`=0, `tx_done`=0, `grant_id`=0, `last_grant`=NUM_REQ-1 (requester 0 has first priority), state=IDLE, counters=0.
- Reset mid-frame: the frame is aborted. `tx`=1 from the next cycle, no `tx_done`, and the priority pointer returns to its reset value.

## Timing
- Accept in cycle k (valid&ready high).
- Start bit: cycles k+1 … k+CLKS_PER_BIT.
- Data bit i (i=0..7): cycles k+1+CLKS_PER_BIT·(1+i) … k+CLKS_PER_BIT·(2+i).
- Stop bit: cycles k+1+9·CLKS_PER_BIT … k+10·CLKS_PER_BIT.
- `tx_done` is high in cycle k+10·CLKS_PER_BIT.
- Cycle k+10·CLKS_PER_BIT+1 is IDLE; the earliest next accept is there.
- Minimum accept-to-accept spacing is 10·CLKS_PER_BIT+1 cycles.
- `busy` is high in cycles k+1 … k+10·CLKS_PER_BIT.
- `req_ready` has zero latency from `req_valid` in IDLE (combinational). `tx`, `busy`, `tx_done` and `grant_id` are registered outputs.
- CLKS_PER_BIT=1 is valid: one cycle per bit, frame in cycles k+1…k+10.

## Test plan
- **Reset:** hold reset 3 cycles with all valid high → `tx`=1, `busy`=0, `req_ready`=0, `tx_done`=0 throughout; after release, the first accept goes to requester 0.
- **Single frame:** CLKS_PER_BIT=4, requester 0 sends 0xA5 →
  - `tx` bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles;
  - `tx_done` at accept+40;
  - `grant_id`=0.
- **All requesters busy:** all four valid held continuously with distinct bytes 0x11, 0x22, 0x33, 0x44 →
  - accept order 0,1,2,3,0;
  - accepts spaced exactly 41 cycles;
  - the serialized bytes match the order.
- **Round-robin skip:** after a grant to 1, only requesters 0 and 2 are valid → 2 is accepted first, then 0 on the next IDLE.
- **Reset mid-frame:** reset during data bit 3 → `tx`=1 and `busy`=0 the next cycle, no `tx_done` pulse; a subsequent request from requester 3 is transmitted as a complete, correct frame.
- **Late valid:** requester 1 raises valid mid-frame → `req_ready`[1] stays 0 until the IDLE cycle after `tx_done`, then is accepted in that cycle.
